// File: rtl/rr_encoder_8to3_if.sv
// Request/result bundle for the 8-to-3 round-robin priority encoder.
// The master side presents request vectors and consumes results; the slave side is the encoder.
interface rr_encoder_8to3_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       in;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [2:0]       out;
  logic             multi;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in, in_valid, mode, out_ready,
    input  in_ready, out, multi, out_valid, drop_cnt
  );

  modport slave (
    input  in, in_valid, mode, out_ready,
    output in_ready, out, multi, out_valid, drop_cnt
  );
endinterface

// File: rtl/rr_encoder_8to3.sv
// 8-to-3 priority encoder with fixed-priority or round-robin selection, a single
// result register with valid/ready handshake, and a saturating all-zero drop counter.
module rr_encoder_8to3 #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_encoder_8to3_if.slave    bus
);

  logic [2:0]       out_q, out_d;
  logic             multi_q, multi_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             accept;
  logic             in_zero;
  logic [7:0]       rr_mask;
  logic [7:0]       rr_masked;
  logic [2:0]       fixed_idx;
  logic [2:0]       masked_idx;
  logic [2:0]       sel_idx;
  logic             in_multi;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_zero      = (bus.in == 8'h00);
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign in_multi     = ((bus.in & (bus.in - 8'd1)) != 8'h00);

  // Bits at or above the pointer get first pick; if none are set, wrap to the bottom.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign rr_mask[gi] = (3'(gi) >= ptr_q);
    end
  endgenerate

  assign rr_masked  = bus.in & rr_mask;
  assign fixed_idx  = lowest_idx(bus.in);
  assign masked_idx = lowest_idx(rr_masked);

  always_comb begin
    sel_idx = fixed_idx;
    if (bus.mode && (rr_masked != 8'h00)) begin
      sel_idx = masked_idx;
    end
  end

  always_comb begin
    out_d       = out_q;
    multi_d     = multi_q;
    ptr_d       = ptr_q;
    drop_cnt_d  = drop_cnt_q;
    out_valid_d = out_valid_q && !bus.out_ready;

    if (accept) begin
      if (in_zero) begin
        if (drop_cnt_q != {CNT_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end else begin
        out_d       = sel_idx;
        multi_d     = in_multi;
        out_valid_d = 1'b1;
        if (bus.mode) begin
          ptr_d = sel_idx + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= 3'd0;
      multi_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ptr_q       <= 3'd0;
      drop_cnt_q  <= '0;
    end else begin
      out_q       <= out_d;
      multi_q     <= multi_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.multi     = multi_q;
  assign bus.out_valid = out_valid_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
